// File: rtl/core_pkg.sv
// Shared execute-stage types: engine identifiers and the result arbiter FSM encoding.
package core_pkg;

  typedef enum logic [1:0] {
    EXEC_ALU = 2'd0,
    EXEC_MUL = 2'd1,
    EXEC_DIV = 2'd2
  } exec_engine_e;

  localparam int N_EXEC_ENGINE = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_HOLD = 2'd2
  } exec_arb_state_e;

endpackage

// File: rtl/core_exec_result_arb.sv
// Execute-stage result arbiter: issues one op to one of N_ENG engines, waits for its
// done (with optional watchdog), registers the result and hands it to writeback.
module core_exec_result_arb
  import core_pkg::*;
#(
  parameter int N_ENG   = N_EXEC_ENGINE,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int SEL_W   = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [SEL_W-1:0]        issue_engine,
  output logic [N_ENG-1:0]        eng_start,
  output logic [N_ENG-1:0]        eng_kill,
  input  logic [N_ENG-1:0]        eng_done,
  input  logic [N_ENG*XLEN-1:0]   eng_result,
  input  logic                    flush,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [XLEN-1:0]         res_data,
  output logic                    res_err,
  output logic                    busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Engine vectors are padded to 2**SEL_W so any index value selects in range.
  localparam int N_PAD = 1 << SEL_W;
  localparam logic             WDOG_EN  = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SEL_W:0]   N_ENG_X  = (SEL_W + 1)'(N_ENG);

  exec_arb_state_e     state_r, state_s;
  logic [SEL_W-1:0]    sel_r, sel_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [XLEN-1:0]     res_data_r, res_data_s;
  logic                res_err_r, res_err_s;

  logic [N_PAD-1:0]      done_pad_s;
  logic [N_PAD*XLEN-1:0] result_pad_s;
  logic                  issue_ready_s;
  logic                  fire_s;
  logic                  legal_s;
  logic                  issue_done_s;
  logic                  sel_done_s;
  logic                  timeout_s;
  logic [N_ENG-1:0]      eng_start_s;
  logic [N_ENG-1:0]      eng_kill_s;

  assign done_pad_s   = N_PAD'(eng_done);
  assign result_pad_s = (N_PAD * XLEN)'(eng_result);

  // Handshake qualifiers and watchdog expiry for the current cycle.
  always_comb begin
    issue_ready_s = !flush && ((state_r == ARB_IDLE) || ((state_r == ARB_HOLD) && res_ready));
    fire_s        = issue_valid && issue_ready_s;
    legal_s       = ({1'b0, issue_engine} < N_ENG_X);
    issue_done_s  = done_pad_s[issue_engine];
    sel_done_s    = done_pad_s[sel_r];
    timeout_s     = WDOG_EN && (state_r == ARB_WAIT) && !sel_done_s && (cnt_r == CNT_LAST);
  end

  // One-hot engine start/kill pulses; start only from IDLE/HOLD, kill only from WAIT.
  always_comb begin
    if (fire_s && legal_s) begin
      eng_start_s = N_ENG'(1'b1) << issue_engine;
    end else begin
      eng_start_s = '0;
    end
    if ((state_r == ARB_WAIT) && (flush || timeout_s)) begin
      eng_kill_s = N_ENG'(1'b1) << sel_r;
    end else begin
      eng_kill_s = '0;
    end
  end

  // Next-state and result capture; flush overrides everything, then a new issue.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    cnt_s      = cnt_r;
    res_data_s = res_data_r;
    res_err_s  = res_err_r;
    if (flush) begin
      state_s = ARB_IDLE;
    end else if (fire_s) begin
      cnt_s = '0;
      if (legal_s) begin
        sel_s = issue_engine;
        if (issue_done_s) begin
          res_data_s = result_pad_s[issue_engine*XLEN +: XLEN];
          res_err_s  = 1'b0;
          state_s    = ARB_HOLD;
        end else begin
          state_s = ARB_WAIT;
        end
      end else begin
        res_data_s = '0;
        res_err_s  = 1'b1;
        state_s    = ARB_HOLD;
      end
    end else begin
      case (state_r)
        ARB_IDLE: begin
          state_s = ARB_IDLE;
        end
        ARB_WAIT: begin
          if (sel_done_s) begin
            res_data_s = result_pad_s[sel_r*XLEN +: XLEN];
            res_err_s  = 1'b0;
            state_s    = ARB_HOLD;
          end else if (timeout_s) begin
            res_data_s = '0;
            res_err_s  = 1'b1;
            state_s    = ARB_HOLD;
          end else if (cnt_r != CNT_MAX) begin
            cnt_s = cnt_r + CNT_W'(1'b1);
          end else begin
            cnt_s = cnt_r;
          end
        end
        ARB_HOLD: begin
          if (res_ready) begin
            state_s = ARB_IDLE;
          end else begin
            state_s = ARB_HOLD;
          end
        end
        default: begin
          state_s = ARB_IDLE;
        end
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB_IDLE;
      sel_r      <= '0;
      cnt_r      <= '0;
      res_data_r <= '0;
      res_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      cnt_r      <= cnt_s;
      res_data_r <= res_data_s;
      res_err_r  <= res_err_s;
    end
  end

  assign issue_ready = issue_ready_s;
  assign eng_start   = eng_start_s;
  assign eng_kill    = eng_kill_s;
  assign res_valid   = (state_r == ARB_HOLD);
  assign res_data    = res_data_r;
  assign res_err     = res_err_r;
  assign busy        = (state_r != ARB_IDLE);

endmodule

// File: doc/core_exec_result_arb.md
Name: core_exec_result_arb

Overview:
- Parametrised successor to the execute-stage engine result mux.
- Issues one op at a time to one of N execution engines (ALU, MUL, DIV, ...) over a start/done handshake.
- Waits for multi-cycle engines and registers the selected result.
- Presents the result to writeback on a valid/ready handshake; supports flush and watchdog timeout.

Parameters:
- N_ENG, 3, number of engines attached; engine index 0..N_ENG-1.
- XLEN, 32, result width.
- TIMEOUT, 64, max cycles in WAIT before declaring error; 0 disables the watchdog.
- SEL_W, $clog2(N_ENG) (min 1), width of the engine index; derived, do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  op available from decode.
- issue_ready  out  1  arbiter can accept op.
- issue_engine  in  SEL_W  target engine index (core_pkg::exec_engine_e cast).
- eng_start  out  N_ENG  one-hot start pulse to engines.
- eng_kill  out  N_ENG  one-hot abort pulse to engines.
- eng_done  in  N_ENG  per-engine done; may assert in the same cycle as start.
- eng_result  in  N_ENG*XLEN  packed engine results; engine i occupies bits [i*XLEN +: XLEN].
- flush  in  1  pipeline flush.
- res_valid  out  1  registered result valid.
- res_ready  in  1  writeback accepts.
- res_data  out  XLEN  registered result.
- res_err  out  1  result is an error (illegal engine or timeout); res_data=0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, sel_q=0, res_data=0, res_err=0, cnt=0. All outputs are low: res_valid, eng_start, eng_kill, busy.
- States:
  - IDLE: nothing outstanding.
  - WAIT: engine sel_q running.
  - HOLD: result registered, res_valid=1.
- issue_ready = !flush && (state==IDLE || (state==HOLD && res_ready)).
- fire = issue_valid && issue_ready.
- On fire with a legal index e:
  - eng_start[e]=1 combinationally in that cycle only; sel_q<=e; cnt<=0.
  - If eng_done[e] in the same cycle: res_data<=eng_result[e], res_err<=0, state<=HOLD. Minimum issue-to-res_valid latency is 1 cycle.
  - Otherwise state<=WAIT.
- On fire with index >= N_ENG: no eng_start; res_data<=0, res_err<=1, state<=HOLD.
- WAIT:
  - eng_done[sel_q] -> capture eng_result[sel_q], res_err<=0, HOLD.
  - eng_done from other engines is ignored.
  - cnt increments each cycle. If TIMEOUT!=0 and cnt==TIMEOUT-1 without done: eng_kill[sel_q] pulses, res_data<=0, res_err<=1, HOLD.
  - Done in the timeout cycle wins; the result is captured.
- HOLD:
  - res_valid=1; res_data and res_err stable until the handshake.
  - res_ready && !issue_valid -> IDLE.
  - res_ready && fire -> back-to-back issue, follows the fire rules (zero bubble).
- flush (highest priority, any state):
  - Next state IDLE, res_valid low next cycle.
  - In WAIT, eng_kill[sel_q] pulses in the flush cycle.
  - No eng_start in a flush cycle.
  - A res_ready in the same cycle as flush in HOLD is still a legal consumption.
- Reset mid-WAIT: state returns to IDLE; eng_kill is not pulsed (engines reset themselves).
- eng_start and eng_kill are never both asserted in one cycle; each is at most one-hot.
- cnt width is $clog2(TIMEOUT+1); cnt saturates and never wraps.

Decomposition:
- core_pkg:
  - extend exec_engine_e (EXEC_ALU=0, EXEC_MUL=1, EXEC_DIV=2);
  - add N_EXEC_ENGINE constant;
  - add exec_arb_state_e {ARB_IDLE, ARB_WAIT, ARB_HOLD}.
- No sub-module required. The indexed result select (eng_result slice by sel) is a plain part-select inline.

Test Plan:
- ALU single-cycle: issue engine 0, eng_done[0] same cycle, result 0x0000_1234 -> res_valid next cycle, res_data=0x1234, res_err=0; with res_ready held 1, 4 back-to-back ops complete in 4 consecutive cycles.
- DIV multi-cycle: issue engine 2, eng_done[2] after 33 cycles with 0xDEAD_BEEF, plus a spurious eng_done[1] at cycle 5 -> busy for 33 cycles, spurious done ignored, res_data=0xDEADBEEF.
- Backpressure: result in HOLD, res_ready=0 for 10 cycles -> res_valid and res_data stable, issue_ready=0, no eng_start.
- Timeout: TIMEOUT=8, issue engine 1, no done -> eng_kill[1] pulses on the 8th WAIT cycle, then res_err=1, res_data=0.
- Flush: flush in WAIT -> eng_kill[sel] pulse, IDLE next cycle, no res_valid. Flush concurrent with issue_valid -> issue_ready=0, no eng_start.
- Illegal index 3 with N_ENG=3 -> no eng_start, res_err=1 next cycle. Async reset mid-WAIT -> all outputs 0 immediately.
